collision_check: RTL and testbench

Frame-rate collision checker that sits directly downstream of the obstacle map. It consumes the packed obstacle top-left coordinates and the player box position, scans the obstacles one per clock after each frame tick, and reports a per-frame hit mask plus a sticky crash flag for the game-control FSM. Scanning sequentially keeps one comparator set regardless of obstacle count.

---
 rtl/game_pkg.sv | 20 ++
 rtl/collision_check_box_overlap.sv | 37 +++
 rtl/collision_check.sv | 163 ++++++++++++++++
 tb/tb_collision_check.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game datapath: FSM states, coordinate
// widths and default screen/object sizes.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_OBS_SIZE = 40;
  localparam int DEF_PLAYER_W = 20;
  localparam int DEF_PLAYER_H = 20;

endpackage

// File: rtl/collision_check_box_overlap.sv
// Combinational strict axis-aligned overlap test between the player box and
// one square obstacle; touching edges do not count as overlap.
module box_overlap
  import game_pkg::*;
#(
  parameter int OBS_SIZE = DEF_OBS_SIZE,
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H
) (
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  input  logic [X_W-1:0] ox,
  input  logic [Y_W-1:0] oy,
  output logic           overlap
);

  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;

  logic [XS_W-1:0] px_e;
  logic [XS_W-1:0] ox_e;
  logic [YS_W-1:0] py_e;
  logic [YS_W-1:0] oy_e;

  // Sums carry one extra bit so a box near the coordinate limit cannot wrap.
  always_comb begin
    px_e    = {1'b0, px};
    ox_e    = {1'b0, ox};
    py_e    = {1'b0, py};
    oy_e    = {1'b0, oy};
    overlap = (px_e < (ox_e + XS_W'(OBS_SIZE))) &&
              (ox_e < (px_e + XS_W'(PLAYER_W))) &&
              (py_e < (oy_e + YS_W'(OBS_SIZE))) &&
              (oy_e < (py_e + YS_W'(PLAYER_H)));
  end

endmodule

// File: rtl/collision_check.sv
// Frame-rate collision checker: scans one obstacle per clock after frame_tick
// and reports a hit mask plus sticky crash. Optional: COLLISION_SCREEN_EDGE_EN.
module collision_check
  import game_pkg::*;
#(
  parameter int N_OBS    = 3,
  parameter int OBS_SIZE = DEF_OBS_SIZE,
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               clr,
  input  logic [X_W-1:0]     player_x,
  input  logic [Y_W-1:0]     player_y,
  input  logic [X_W*N_OBS-1:0] obstacle_x,
  input  logic [Y_W*N_OBS-1:0] obstacle_y,
  output logic               busy,
  output logic               done,
  output logic [N_OBS-1:0]   hit_mask,
  output logic               hit,
  output logic               crash
);

  localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBS - 1);
  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;

`ifdef COLLISION_SCREEN_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [N_OBS-1:0]   work_r, work_s;
  logic               snap_s, report_s;

  logic [X_W-1:0]       px_r;
  logic [Y_W-1:0]       py_r;
  logic [X_W*N_OBS-1:0] obs_x_r;
  logic [Y_W*N_OBS-1:0] obs_y_r;

  logic [X_W-1:0] sel_x_s;
  logic [Y_W-1:0] sel_y_s;
  logic           overlap_s;
  logic           edge_s;
  logic           hit_s;

  logic             busy_r, done_r, hit_r, crash_r;
  logic [N_OBS-1:0] hit_mask_r;

  assign sel_x_s = obs_x_r[X_W*idx_r +: X_W];
  assign sel_y_s = obs_y_r[Y_W*idx_r +: Y_W];

  box_overlap #(
    .OBS_SIZE (OBS_SIZE),
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H)
  ) u_overlap (
    .px      (px_r),
    .py      (py_r),
    .ox      (sel_x_s),
    .oy      (sel_y_s),
    .overlap (overlap_s)
  );

  // Off-screen test on the snapshot; folded away when the edge option is off.
  always_comb begin
    edge_s = (({1'b0, px_r} + XS_W'(PLAYER_W)) > XS_W'(SCREEN_W)) ||
             (({1'b0, py_r} + YS_W'(PLAYER_H)) > YS_W'(SCREEN_H));
    hit_s  = (|work_s) | (EDGE_EN & edge_s);
  end

  // Next-state, scan index and working-mask update.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    work_s   = work_r;
    snap_s   = 1'b0;
    report_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_tick) begin
          state_s = SCAN;
          idx_s   = '0;
          work_s  = '0;
          snap_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        work_s[idx_r] = overlap_s;
        if (idx_r == LAST_IDX) begin
          state_s  = REPORT;
          report_s = 1'b1;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      REPORT: begin
        state_s = IDLE;
        idx_s   = '0;
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // State, snapshot and registered outputs; results load on the edge into REPORT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      work_r     <= '0;
      px_r       <= '0;
      py_r       <= '0;
      obs_x_r    <= '0;
      obs_y_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hit_mask_r <= '0;
      hit_r      <= 1'b0;
      crash_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      work_r  <= work_s;
      if (snap_s) begin
        px_r    <= player_x;
        py_r    <= player_y;
        obs_x_r <= obstacle_x;
        obs_y_r <= obstacle_y;
      end
      busy_r <= (state_s != IDLE);
      done_r <= report_s;
      if (report_s) begin
        hit_mask_r <= work_s;
        hit_r      <= hit_s;
      end
      if (report_s && hit_s) begin
        crash_r <= 1'b1;
      end else if (clr) begin
        crash_r <= 1'b0;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign hit_mask = hit_mask_r;
  assign hit      = hit_r;
  assign crash    = crash_r;

endmodule

// File: tb/tb_collision_check.sv
// Self-checking bench for collision_check: directed literal cases plus
// randomized traffic compared every cycle against a frame-level model.
module tb_collision_check;

  localparam int N_OBS = 3;
  localparam int OBS   = 40;
  localparam int PW    = 20;
  localparam int PH    = 20;
  localparam int SW    = 640;
  localparam int SH    = 480;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_tick = 1'b0;
  logic              clr = 1'b0;
  logic [9:0]        player_x = '0;
  logic [8:0]        player_y = '0;
  logic [10*N_OBS-1:0] obstacle_x = '0;
  logic [9*N_OBS-1:0]  obstacle_y = '0;
  logic              busy, done, hit, crash;
  logic [N_OBS-1:0]  hit_mask;

  int checks = 0;
  int failures = 0;

  // model state
  bit              model_valid = 1'b0;
  int              rem = 0;
  bit [N_OBS-1:0]  pend_mask = '0;
  bit              pend_hit = 1'b0;
  bit              e_busy = 1'b0, e_done = 1'b0, e_hit = 1'b0, e_crash = 1'b0;
  bit [N_OBS-1:0]  e_mask = '0;

  collision_check #(
    .N_OBS(N_OBS), .OBS_SIZE(OBS), .PLAYER_W(PW), .PLAYER_H(PH),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .clr(clr),
    .player_x(player_x), .player_y(player_y),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .busy(busy), .done(done), .hit_mask(hit_mask), .hit(hit), .crash(crash)
  );

  always #5 clk = ~clk;

  function automatic bit overlaps(int px, int py, int ox, int oy);
    return (px < ox + OBS) && (ox < px + PW) && (py < oy + OBS) && (oy < py + PH);
  endfunction

  function automatic bit off_screen(int px, int py);
`ifdef COLLISION_SCREEN_EDGE_EN
    return (px + PW > SW) || (py + PH > SH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and apply the frame-level rules to the inputs seen at that edge.
  task automatic step();
    bit accept;
    @(posedge clk);
    #1;
    model_valid = 1'b1;
    if (!rst_n) begin
      rem = 0; e_busy = 0; e_done = 0; e_mask = '0; e_hit = 0; e_crash = 0;
    end else begin
      accept = (rem == 0) && frame_tick;
      if (rem > 0) rem--;
      if (accept) begin
        rem = N_OBS + 1;
        pend_mask = '0;
        for (int i = 0; i < N_OBS; i++)
          pend_mask[i] = overlaps(int'(player_x), int'(player_y),
                                  int'(obstacle_x[10*i +: 10]), int'(obstacle_y[9*i +: 9]));
        pend_hit = (pend_mask != '0) || off_screen(int'(player_x), int'(player_y));
      end
      e_done = (rem == 1);
      if (e_done) begin
        e_mask = pend_mask;
        e_hit  = pend_hit;
      end
      if (e_done && pend_hit) e_crash = 1'b1;
      else if (clr) e_crash = 1'b0;
      e_busy = (rem > 0);
    end
  endtask

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("hit_mask", int'(hit_mask), int'(e_mask));
      chk("hit", int'(hit), int'(e_hit));
      chk("crash", int'(crash), int'(e_crash));
    end
  end

  task automatic run_frame(input int px, input int py, output int lat);
    frame_tick = 1'b0;
    step();
    player_x = 10'(px);
    player_y = 9'(py);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, ndone, dcyc, d, px;

    // reset
    rst_n = 1'b0;
    step();
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_outputs", int'({done, hit_mask, hit, crash}), 0);
    rst_n = 1'b1;
    obstacle_x = {10'd160, 10'd230, 10'd300};
    obstacle_y = {9'd20, 9'd200, 9'd300};

    run_frame(310, 310, lat);
    chk("t1_latency", lat, 4);
    chk("t1_mask", int'(hit_mask), 1);
    chk("t1_hit", int'(hit), 1);
    chk("t1_crash", int'(crash), 1);

    run_frame(225, 215, lat);
    chk("t2_mask", int'(hit_mask), 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_clr_crash", int'(crash), 0);
    chk("t2_mask_held", int'(hit_mask), 2);

    run_frame(280, 300, lat);
    chk("t3_touch_mask", int'(hit_mask), 0);
    chk("t3_touch_hit", int'(hit), 0);

    // second tick during scan is ignored
    step();
    player_x = 10'd310; player_y = 9'd310;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 3; c < 10; c++) begin
      if (done) begin ndone++; dcyc = c; end
      step();
    end
    chk("t4_done_count", ndone, 1);
    chk("t4_done_cycle", dcyc, 4);

    // reset in mid-scan
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t5_reset_busy", int'(busy), 0);
    chk("t5_reset_outputs", int'({done, hit_mask, hit, crash}), 0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      step();
    end
    chk("t5_no_done", ndone, 0);
    run_frame(310, 310, lat);
    chk("t5_retick_mask", int'(hit_mask), 1);
    chk("t5_retick_latency", lat, 4);

    run_frame(0, 470, lat);
    chk("t6_edge_mask", int'(hit_mask), 0);
`ifdef COLLISION_SCREEN_EDGE_EN
    chk("t6_edge_hit", int'(hit), 1);
`else
    chk("t6_edge_hit", int'(hit), 0);
`endif

    // randomized traffic, map and player changing under running scans
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N_OBS; i++) begin
          obstacle_x[10*i +: 10] = 10'($urandom_range(0, 1023));
          obstacle_y[9*i +: 9]   = 9'($urandom_range(0, 511));
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        d  = int'($urandom_range(0, 90));
        px = int'(obstacle_x[9:0]) - 45 + d;
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        player_x = 10'(px);
        d  = int'($urandom_range(0, 90));
        px = int'(obstacle_y[8:0]) - 45 + d;
        if (px < 0) px = 0;
        if (px > 511) px = 511;
        player_y = 9'(px);
      end else begin
        player_x = 10'($urandom_range(0, 1023));
        player_y = 9'($urandom_range(0, 511));
      end
      frame_tick = ($urandom_range(0, 2) == 0);
      clr        = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 79) != 0);
      step();
    end
    frame_tick = 1'b0; clr = 1'b0; rst_n = 1'b1;
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
